// File: rtl/parking_time_pkg.sv
// Shared constants, width helpers and the hh:mm time type for the parking time base.
// The optional alarm in parking_time_base is enabled with the PARKING_ALARM_EN macro.
package parking_time_pkg;

   localparam int DEF_TICKS_PER_MIN = 60;
   localparam int DEF_STEP          = 30;
   localparam int DEF_MIN_PER_HOUR  = 60;
   localparam int DEF_HOURS_PER_DAY = 24;
   localparam int DEF_DAY_W         = 12;

   // A modulus of 1 still needs a one-bit counter.
   function automatic int min_w(input int min_per_hour);
      return (min_per_hour > 1) ? $clog2(min_per_hour) : 1;
   endfunction

   function automatic int hour_w(input int hours_per_day);
      return (hours_per_day > 1) ? $clog2(hours_per_day) : 1;
   endfunction

   localparam int DEF_MIN_W  = min_w(DEF_MIN_PER_HOUR);
   localparam int DEF_HOUR_W = hour_w(DEF_HOURS_PER_DAY);

   typedef struct packed {
      logic [DEF_HOUR_W-1:0] hh;
      logic [DEF_MIN_W-1:0]  mm;
   } time_t;

endpackage

// File: rtl/parking_time_base_mod_counter.sv
// Modulo-N counter with synchronous clear and load; wrap flags the enabled step
// from MODULUS-1 back to zero so the next stage can chain on it.
module mod_counter
   import parking_time_pkg::*;
#(
   parameter int WIDTH   = 6,
   parameter int MODULUS = 60
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             clr,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   output logic [WIDTH-1:0] count,
   output logic             wrap
);

   localparam logic [WIDTH-1:0] LAST = WIDTH'(MODULUS - 1);

   // wrap is only meaningful when the counter really steps this cycle
   assign wrap = en && !clr && !load && (count == LAST);

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values of its neighbours.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count <= '0;
      end else if (clr) begin
         count <= '0;
      end else if (load) begin
         count <= load_val;
      end else if (en) begin
         count <= wrap ? '0 : count + WIDTH'(1);
      end
   end

endmodule

// File: rtl/parking_time_base.sv
// Time-of-day base: sub-minute accumulator, minute/hour/day counters, strobes and a
// validated time load. Optional alarm compare is built when PARKING_ALARM_EN is defined.
module parking_time_base
   import parking_time_pkg::*;
#(
   parameter int TICKS_PER_MIN = DEF_TICKS_PER_MIN,
   parameter int STEP          = DEF_STEP,
   parameter int MIN_PER_HOUR  = DEF_MIN_PER_HOUR,
   parameter int HOURS_PER_DAY = DEF_HOURS_PER_DAY,
   parameter int DAY_W         = DEF_DAY_W,
   localparam int HOUR_W       = hour_w(HOURS_PER_DAY),
   localparam int MIN_W        = min_w(MIN_PER_HOUR)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              clear,
   input  logic              load_valid,
   output logic              load_ready,
   input  logic [HOUR_W-1:0] load_hour,
   input  logic [MIN_W-1:0]  load_min,
   output logic              load_err,
   output logic [MIN_W-1:0]  minute,
   output logic [HOUR_W-1:0] hour,
   output logic [DAY_W-1:0]  day_count,
   output logic              hour_pulse,
   output logic              day_pulse
`ifdef PARKING_ALARM_EN
   ,
   input  logic              alarm_set,
   input  logic [HOUR_W-1:0] alarm_hour,
   input  logic [MIN_W-1:0]  alarm_min,
   output logic              alarm
`endif
);

   if (STEP < 1 || STEP > TICKS_PER_MIN) begin : g_bad_step
      $error("parking_time_base: STEP must lie in 1..TICKS_PER_MIN");
   end

   // Wide enough for acc + STEP, which stays below 2*TICKS_PER_MIN.
   localparam int ACC_W = $clog2(2 * TICKS_PER_MIN);

   logic [ACC_W-1:0] acc;
   logic [ACC_W-1:0] acc_sum;
   logic             load_req;
   logic             range_ok;
   logic             load_ok;
   logic             load_bad;
   logic             tick;
   logic             carry;
   logic             min_wrap;
   logic             hour_wrap;

   assign load_ready = !rst;
   assign load_req   = load_valid && load_ready && !clear;
   assign range_ok   = (int'(load_hour) < HOURS_PER_DAY) && (int'(load_min) < MIN_PER_HOUR);
   assign load_ok    = load_req && range_ok;
   assign load_bad   = load_req && !range_ok;

   // Any accepted load request, good or bad, swallows the tick of that cycle.
   assign tick    = start && !clear && !load_req;
   assign acc_sum = acc + ACC_W'(STEP);
   assign carry   = tick && (acc_sum >= ACC_W'(TICKS_PER_MIN));

   // NOTE: reset is asynchronous and active-high; every register lists posedge rst
   // so the outputs drop the moment rst rises, without waiting for a clock.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         acc <= '0;
      end else if (clear || load_ok) begin
         acc <= '0;
      end else if (tick) begin
         acc <= carry ? acc_sum - ACC_W'(TICKS_PER_MIN) : acc_sum;
      end
   end

   mod_counter #(
      .WIDTH   (MIN_W),
      .MODULUS (MIN_PER_HOUR)
   ) u_minute (
      .clk      (clk),
      .rst      (rst),
      .en       (carry),
      .clr      (clear),
      .load     (load_ok),
      .load_val (load_min),
      .count    (minute),
      .wrap     (min_wrap)
   );

   mod_counter #(
      .WIDTH   (HOUR_W),
      .MODULUS (HOURS_PER_DAY)
   ) u_hour (
      .clk      (clk),
      .rst      (rst),
      .en       (min_wrap),
      .clr      (clear),
      .load     (load_ok),
      .load_val (load_hour),
      .count    (hour),
      .wrap     (hour_wrap)
   );

   // Strobes are registered alongside the carry so they line up with the new time.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         hour_pulse <= 1'b0;
         day_pulse  <= 1'b0;
         load_err   <= 1'b0;
         day_count  <= '0;
      end else begin
         hour_pulse <= min_wrap;
         day_pulse  <= hour_wrap;
         load_err   <= load_bad;
         if (clear) begin
            day_count <= '0;
         end else if (hour_wrap && (day_count != '1)) begin
            day_count <= day_count + DAY_W'(1);
         end
      end
   end

`ifdef PARKING_ALARM_EN
   logic [MIN_W-1:0]  min_next;
   logic [HOUR_W-1:0] hour_next;
   logic [HOUR_W-1:0] al_hour;
   logic [MIN_W-1:0]  al_min;
   logic              al_armed;
   logic              al_valid;

   // Time the counters will show after this edge when the minute advances.
   assign min_next  = min_wrap ? '0 : minute + MIN_W'(1);
   assign hour_next = hour_wrap ? '0 : (min_wrap ? hour + HOUR_W'(1) : hour);
   assign al_valid  = (int'(alarm_hour) < HOURS_PER_DAY) && (int'(alarm_min) < MIN_PER_HOUR);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         al_hour  <= '0;
         al_min   <= '0;
         al_armed <= 1'b0;
         alarm    <= 1'b0;
      end else begin
         if (alarm_set && al_valid) begin
            al_hour  <= alarm_hour;
            al_min   <= alarm_min;
            al_armed <= 1'b1;
         end
         alarm <= al_armed && carry && (hour_next == al_hour) && (min_next == al_min);
      end
   end
`endif

endmodule
